// File: rtl/parking_pkg.sv
// parking_pkg: shared widths and encodings for the parking occupancy controller
package parking_pkg;
   localparam int WIDTH = 8;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CALC = 1'b1;
endpackage

// File: rtl/parking_edge_det.sv
// parking_edge_det: rising-edge detector with a single-event pending flag
module parking_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   input  logic clr,
   output logic pend
);
   logic prev;
   // a new edge wins over a same-cycle clear so no event is lost
   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 1'b0;
         pend <= 1'b0;
      end else begin
         prev <= sig;
         pend <= (sig & ~prev) | (pend & ~clr);
      end
   end
endmodule

// File: rtl/parking_count_ctrl.sv
// parking_count_ctrl: occupancy counter driving an external 8-bit adder/subtractor
module parking_count_ctrl
   import parking_pkg::*;
#(
   parameter logic [WIDTH-1:0] CAPACITY = 8'd200
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             car_in,
   input  logic             car_out,
   output logic             add_s,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] free,
   output logic             full,
   output logic             empty,
   output logic             entry_grant,
   output logic             entry_deny,
   output logic             exit_err,
   output logic             arith_err,
   output logic             busy
);
   logic [0:0] state;
   logic       op;
   logic       pend_in, pend_out, clr_in, clr_out;
   parking_edge_det u_in (
      .clk(clk), .reset(reset), .sig(car_in), .clr(clr_in), .pend(pend_in)
   );
   parking_edge_det u_out (
      .clk(clk), .reset(reset), .sig(car_out), .clr(clr_out), .pend(pend_out)
   );
   always_comb begin
      busy    = state == ST_CALC;
      clr_in  = !busy && pend_in;
      clr_out = !busy && pend_out;
      add_s   = busy ? op : OP_ADD;
      add_a   = busy ? count : '0;
      add_b   = busy ? 8'd1 : '0;
   end
   // simultaneous in/out events cancel without touching the adder
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         op          <= OP_ADD;
         count       <= '0;
         free        <= CAPACITY;
         full        <= 1'b0;
         empty       <= 1'b1;
         entry_grant <= 1'b0;
         entry_deny  <= 1'b0;
         exit_err    <= 1'b0;
         arith_err   <= 1'b0;
      end else begin
         entry_grant <= 1'b0;
         entry_deny  <= 1'b0;
         exit_err    <= 1'b0;
         if (state == ST_CALC) begin
            count <= add_sum;
            free  <= op == OP_ADD ? free - 8'd1 : free + 8'd1;
            full  <= add_sum == CAPACITY;
            empty <= add_sum == '0;
            if (add_cout != op) arith_err <= 1'b1;
            state <= ST_IDLE;
         end else if (pend_in && pend_out) begin
            entry_grant <= 1'b1;
         end else if (pend_in) begin
            if (full) begin
               entry_deny <= 1'b1;
            end else begin
               entry_grant <= 1'b1;
               op          <= OP_ADD;
               state       <= ST_CALC;
            end
         end else if (pend_out) begin
            if (empty) begin
               exit_err <= 1'b1;
            end else begin
               op    <= OP_SUB;
               state <= ST_CALC;
            end
         end
      end
   end
endmodule

// File: tb/tb_parking_count_ctrl.sv
// tb_parking_count_ctrl: scoreboard bench with adder models beside two controller instances
module tb_parking_count_ctrl;
   localparam logic [7:0] CAP = 8'd200;
   localparam logic [7:0] CAP3 = 8'd3;
   localparam logic [2:0] K_RST = 3'd0, K_GNT = 3'd1, K_DNY = 3'd2, K_XER = 3'd3, K_UPD = 3'd4;
   typedef struct packed {
      logic [2:0] k;
      logic [7:0] c;
      logic       bz;
      logic       s;
      logic       ar;
   } item_t;

   logic clk, reset, ci, co, s, cout, fu, em, gnt, dny, xer, ar, bz, bad;
   logic [7:0] a, b, sum, cnt, fr;
   logic [8:0] r;
   logic reset3, ci3, co3, s3, cout3, fu3, em3, gnt3, dny3, xer3, ar3, bz3;
   logic [7:0] a3, b3, sum3, cnt3, fr3;
   logic [8:0] r3;

   int checks = 0, failures = 0;
   item_t q[$], q3[$];
   item_t e_m, e_3;
   logic rst_q, rst_q3, was_busy, was_busy3, cap_s, cap_s3;
   logic [7:0] cap_a, cap_a3;
   logic [2:0] pk, pk3;

   // adder_subtractor_8bit behaviour; bad flips Cout to emulate a faulty stage
   assign r = s ? {1'b0, a} + {1'b0, ~b} + 9'd1 : {1'b0, a} + {1'b0, b};
   assign sum = r[7:0];
   assign cout = r[8] ^ bad;
   assign r3 = s3 ? {1'b0, a3} + {1'b0, ~b3} + 9'd1 : {1'b0, a3} + {1'b0, b3};
   assign sum3 = r3[7:0];
   assign cout3 = r3[8];

   parking_count_ctrl #(.CAPACITY(CAP)) dut (
      .clk(clk), .reset(reset), .car_in(ci), .car_out(co),
      .add_s(s), .add_a(a), .add_b(b), .add_sum(sum), .add_cout(cout),
      .count(cnt), .free(fr), .full(fu), .empty(em),
      .entry_grant(gnt), .entry_deny(dny), .exit_err(xer), .arith_err(ar), .busy(bz)
   );
   parking_count_ctrl #(.CAPACITY(CAP3)) dut3 (
      .clk(clk), .reset(reset3), .car_in(ci3), .car_out(co3),
      .add_s(s3), .add_a(a3), .add_b(b3), .add_sum(sum3), .add_cout(cout3),
      .count(cnt3), .free(fr3), .full(fu3), .empty(em3),
      .entry_grant(gnt3), .entry_deny(dny3), .exit_err(xer3), .arith_err(ar3), .busy(bz3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic check_item(input string tag, input item_t e, input logic [2:0] k, input logic [7:0] cap,
                             input logic [7:0] c, input logic [7:0] f, input logic fu_, input logic em_,
                             input logic bz_, input logic ar_);
      chk({tag, "_kind"}, k, e.k);
      chk({tag, "_count"}, c, e.c);
      chk({tag, "_free"}, f, cap - e.c);
      chk({tag, "_full"}, fu_, e.c == cap);
      chk({tag, "_empty"}, em_, e.c == 8'd0);
      chk({tag, "_busy"}, bz_, e.bz);
      chk({tag, "_arith_err"}, ar_, e.ar);
   endtask

   always @(posedge clk) begin
      rst_q <= reset;
      rst_q3 <= reset3;
   end

   always @(negedge clk) begin
      pk = gnt ? K_GNT : dny ? K_DNY : K_XER;
      if (rst_q === 1'b1) begin
         if (q.size() == 0) chk("main_unexpected_reset", 8'd1, 8'd0);
         else begin
            e_m = q.pop_front();
            check_item("main_rst", e_m, K_RST, CAP, cnt, fr, fu, em, bz, ar);
            chk("main_rst_pulses", {5'd0, gnt, dny, xer}, 8'd0);
            chk("main_rst_adder", {7'd0, s} | a | b, 8'd0);
         end
      end else begin
         if (gnt || dny || xer) begin
            if (q.size() == 0) chk("main_unexpected_pulse", {5'd0, gnt, dny, xer}, 8'd0);
            else begin
               e_m = q.pop_front();
               check_item("main_pulse", e_m, pk, CAP, cnt, fr, fu, em, bz, ar);
            end
         end
         if (was_busy === 1'b1) begin
            if (q.size() == 0) chk("main_unexpected_update", cnt, 8'hff);
            else begin
               e_m = q.pop_front();
               check_item("main_upd", e_m, K_UPD, CAP, cnt, fr, fu, em, bz, ar);
               chk("main_upd_add_s", {7'd0, cap_s}, {7'd0, e_m.s});
               chk("main_upd_add_a", cap_a, e_m.s ? e_m.c + 8'd1 : e_m.c - 8'd1);
            end
         end
         chk(bz ? "main_calc_add_b" : "main_idle_add_b", b, bz ? 8'd1 : 8'd0);
      end
      was_busy <= bz === 1'b1 && !reset;
      cap_s <= s;
      cap_a <= a;
   end

   always @(negedge clk) begin
      pk3 = gnt3 ? K_GNT : dny3 ? K_DNY : K_XER;
      if (rst_q3 === 1'b1) begin
         if (q3.size() == 0) chk("cap3_unexpected_reset", 8'd1, 8'd0);
         else begin
            e_3 = q3.pop_front();
            check_item("cap3_rst", e_3, K_RST, CAP3, cnt3, fr3, fu3, em3, bz3, ar3);
         end
      end else begin
         if (gnt3 || dny3 || xer3) begin
            if (q3.size() == 0) chk("cap3_unexpected_pulse", {5'd0, gnt3, dny3, xer3}, 8'd0);
            else begin
               e_3 = q3.pop_front();
               check_item("cap3_pulse", e_3, pk3, CAP3, cnt3, fr3, fu3, em3, bz3, ar3);
            end
         end
         if (was_busy3 === 1'b1) begin
            if (q3.size() == 0) chk("cap3_unexpected_update", cnt3, 8'hff);
            else begin
               e_3 = q3.pop_front();
               check_item("cap3_upd", e_3, K_UPD, CAP3, cnt3, fr3, fu3, em3, bz3, ar3);
               chk("cap3_upd_add_s", {7'd0, cap_s3}, {7'd0, e_3.s});
               chk("cap3_upd_add_a", cap_a3, e_3.s ? e_3.c + 8'd1 : e_3.c - 8'd1);
            end
         end
      end
      was_busy3 <= bz3 === 1'b1 && !reset3;
      cap_s3 <= s3;
      cap_a3 <= a3;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic ex(input logic [2:0] k, input logic [7:0] c, input logic bz_, input logic s_, input logic ar_);
      q.push_back({k, c, bz_, s_, ar_});
   endtask

   task automatic ex3(input logic [2:0] k, input logic [7:0] c, input logic bz_, input logic s_, input logic ar_);
      q3.push_back({k, c, bz_, s_, ar_});
   endtask

   task automatic pulse_in();
      ci = 1'b1;
      tick();
      ci = 1'b0;
   endtask

   task automatic pulse_out();
      co = 1'b1;
      tick();
      co = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ex(K_RST, 8'd0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; reset3 = 1'b1;
      ci = 1'b0; co = 1'b0; ci3 = 1'b0; co3 = 1'b0; bad = 1'b0;
      ex(K_RST, 8'd0, 1'b0, 1'b0, 1'b0);
      ex3(K_RST, 8'd0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0; reset3 = 1'b0;
      idle(2);
      // single entry: grant at t+1 while in CALC, count 1 / free 199 after t+2
      ex(K_GNT, 8'd0, 1'b1, 1'b0, 1'b0);
      ex(K_UPD, 8'd1, 1'b0, 1'b0, 1'b0);
      pulse_in();
      idle(4);
      // exit on an empty lot
      do_reset();
      idle(2);
      ex(K_XER, 8'd0, 1'b0, 1'b0, 1'b0);
      pulse_out();
      idle(4);
      // fill to 5
      for (int k = 0; k < 5; k++) begin
         ex(K_GNT, 8'(k), 1'b1, 1'b0, 1'b0);
         ex(K_UPD, 8'(k + 1), 1'b0, 1'b0, 1'b0);
         pulse_in();
         idle(3);
      end
      // simultaneous in and out cancel
      ex(K_GNT, 8'd5, 1'b0, 1'b0, 1'b0);
      ci = 1'b1; co = 1'b1;
      tick();
      ci = 1'b0; co = 1'b0;
      idle(4);
      // exit edge while the entry is in CALC
      ex(K_GNT, 8'd5, 1'b1, 1'b0, 1'b0);
      ex(K_UPD, 8'd6, 1'b0, 1'b0, 1'b0);
      ex(K_UPD, 8'd5, 1'b0, 1'b1, 1'b0);
      ci = 1'b1;
      tick();
      ci = 1'b0;
      tick();
      co = 1'b1;
      tick();
      co = 1'b0;
      idle(5);
      // wrong carry on one ADD, flag stays set through a clean SUB
      bad = 1'b1;
      ex(K_GNT, 8'd5, 1'b1, 1'b0, 1'b0);
      ex(K_UPD, 8'd6, 1'b0, 1'b0, 1'b1);
      pulse_in();
      idle(4);
      bad = 1'b0;
      ex(K_UPD, 8'd5, 1'b0, 1'b1, 1'b1);
      pulse_out();
      idle(4);
      // reset in the middle of CALC abandons the update
      ex(K_GNT, 8'd5, 1'b1, 1'b0, 1'b1);
      pulse_in();
      for (int i = 0; i < 10 && bz !== 1'b1; i++) tick();
      chk("wait_busy", {7'd0, bz}, 8'd1);
      do_reset();
      idle(2);
      ex(K_GNT, 8'd0, 1'b1, 1'b0, 1'b0);
      ex(K_UPD, 8'd1, 1'b0, 1'b0, 1'b0);
      pulse_in();
      idle(4);
      // CAPACITY 3: three grants then a deny at full
      for (int k = 0; k < 3; k++) begin
         ex3(K_GNT, 8'(k), 1'b1, 1'b0, 1'b0);
         ex3(K_UPD, 8'(k + 1), 1'b0, 1'b0, 1'b0);
         ci3 = 1'b1;
         tick();
         ci3 = 1'b0;
         idle(3);
      end
      ex3(K_DNY, 8'd3, 1'b0, 1'b0, 1'b0);
      ci3 = 1'b1;
      tick();
      ci3 = 1'b0;
      idle(5);
      chk("main_scoreboard_drained", 8'(q.size()), 8'd0);
      chk("cap3_scoreboard_drained", 8'(q3.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/parking_count_ctrl.md
Name: parking_count_ctrl

Overview:
Occupancy controller for the smart parking lot. It turns entry/exit sensor events into increment/decrement requests for the external 8-bit adder_subtractor stage, drives that stage's S/A/B inputs, and registers its Sum/Cout result as the occupancy count. It also produces free-space, full and empty status and grant/deny pulses for the gate logic downstream.

Parameters:
CAPACITY, 8'd200, number of spaces in the lot; legal range 1..255.

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
car_in  input  1  entry sensor level, already synchronised to clk
car_out  input  1  exit sensor level, already synchronised to clk
add_s  output  1  to the adder's S input; 0 = add, 1 = subtract
add_a  output  8  to the adder's A input; current count
add_b  output  8  to the adder's B input; constant 8'd1 while busy, 0 otherwise
add_sum  input  8  from the adder's Sum output
add_cout  input  1  from the adder's Cout output
count  output  8  registered occupancy
free  output  8  registered CAPACITY - count
full  output  1  count == CAPACITY
empty  output  1  count == 0
entry_grant  output  1  one-cycle pulse when an entry is accepted
entry_deny  output  1  one-cycle pulse when an entry is rejected because the lot is full
exit_err  output  1  one-cycle pulse when an exit is seen while the lot is empty
arith_err  output  1  sticky flag for an unexpected adder carry; cleared only by reset
busy  output  1  high while in CALC

Behaviour:
- Reset (synchronous, active-high) values: count = 0, free = CAPACITY, empty = 1, full = 0, all pulses 0, arith_err = 0, busy = 0, add_s = 0, add_a = 0, add_b = 0. Edge-detect registers are cleared to 0 and pending flags are cleared.
- Edge detection: the block registers car_in and car_out each cycle. A rising edge (cur = 1, prev = 0) sets pend_in or pend_out. Each pending flag holds one event.
- A second edge on the same input while its flag is still set is dropped. No counter is kept.
- The FSM has two states, IDLE and CALC.
- In IDLE, pending flags are evaluated in the cycle after the edge:
  - pend_in and pend_out both set: the events cancel. No adder operation; count is unchanged. Pulse entry_grant and clear both flags. This happens even when the lot is full; exit_err is not pulsed.
  - pend_in only, full = 1: pulse entry_deny, clear the flag, stay in IDLE.
  - pend_in only, not full: set op = ADD, pulse entry_grant, clear the flag, go to CALC.
  - pend_out only, empty = 1: pulse exit_err, clear the flag, stay in IDLE.
  - pend_out only, not empty: set op = SUB, clear the flag, go to CALC.
- In CALC:
  - Drive add_s = op, add_a = count, add_b = 8'd1. These are combinational from state and count.
  - At the end of the cycle, count <= add_sum and free <= free -/+ 1, computed internally. full and empty are updated from the new count in the same edge.
  - Then return to IDLE.
- Latency: for a sensor edge sampled at edge t, the grant pulse is at t+1 and the new count is visible after edge t+2. The minimum spacing between accepted updates is 2 cycles.
- Edges arriving during CALC set their pending flags and are serviced in the next IDLE cycle, so no event is lost.
- Carry check: ADD expects add_cout = 0 and SUB expects add_cout = 1 (no borrow). Any mismatch sets arith_err. count still takes add_sum.
- count never exceeds CAPACITY and never goes below 0. This is guaranteed by the full/empty gating.
- Reset asserted in CALC: the update is abandoned and all reset values apply on that edge.

Decomposition:
- Package parking_pkg holds:
  - op encoding OP_ADD = 1'b0, OP_SUB = 1'b1, matching the adder's S;
  - state encoding ST_IDLE, ST_CALC;
  - WIDTH = 8.
- One natural sub-module: parking_edge_det (register, rising-edge detect, pending flag with clear). It is instantiated twice, for car_in and car_out.
- adder_subtractor_8bit stays external. The bench may instantiate it beside this block.

Test Plan:
- Reset, then one car_in pulse -> entry_grant at t+1, count = 1, free = 199, empty = 0 after t+2.
- CAPACITY = 3, four car_in pulses spaced 4 cycles apart -> three grants, count = 3, full = 1, then entry_deny on the 4th with count still 3.
- From reset, one car_out pulse -> exit_err pulse, count = 0, add_s never 1.
- count = 5, car_in and car_out rising in the same cycle -> entry_grant, count stays 5, busy stays 0.
- count = 5, car_in edge, then car_out edge during CALC -> count = 6, then 5. add_s is 0 in the first CALC and 1 in the second; no event is dropped.
- Adder model forced to wrong Cout on one ADD -> arith_err = 1 and stays set until reset. Reset asserted mid-CALC -> count = 0 on the next cycle.
